cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one cache_system_2level instance (read-only, two-level, registered outputs) between NUM_REQ requesters.
- Accepts one request at a time over a per-requester valid/ready handshake and drives the cache read pulse.
- Captures the cache's data and hit flags one cycle after issue and returns them to the granted requester over a valid/ready response channel.
- Maintains saturating L1-hit, L2-hit and miss statistics counters.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- ADDR_WIDTH, 11, cache address width.
- DATA_WIDTH, 11, cache data width.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed request addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  output  NUM_REQ  one-hot request accept.
- resp_valid  output  NUM_REQ  one-hot response valid.
- resp_ready  input  NUM_REQ  per-requester response ready.
- resp_data  output  DATA_WIDTH  response data, shared by all requesters.
- resp_l1_hit  output  1  response was an L1 hit.
- resp_l2_hit  output  1  response was an L2 hit.
- cache_addr  output  ADDR_WIDTH  address to the cache.
- cache_read  output  1  one-cycle read strobe to the cache.
- cache_read_data  input  DATA_WIDTH  cache read_data.
- cache_l1_hit  input  1  cache l1_hit.
- cache_l2_hit  input  1  cache l2_hit.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- stat_clear  input  1  synchronous clear of all statistics counters.
- stat_l1_hits  output  CNT_WIDTH  count of L1 hits.
- stat_l2_hits  output  CNT_WIDTH  count of L2 hits.
- stat_misses  output  CNT_WIDTH  count of misses.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - state=IDLE; rr pointer=0; grant_id=0; cache_addr=0; cache_read=0.
  - resp_valid=0; resp_data=0; resp_l1_hit=0; resp_l2_hit=0.
  - all statistics counters=0; req_ready=0 except as decoded combinationally in IDLE.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from the rr pointer upward with wrap-around.
  - req_ready[winner] is driven combinationally high in this cycle; all other req_ready bits are 0.
  - On the clock edge: latch req_addr[winner] into cache_addr, set grant_id=winner, set rr pointer=(winner+1) mod NUM_REQ, go to ISSUE.
  - If no req_valid is high: all req_ready=0 and the state is held.
- ISSUE: cache_read=1 for exactly this one cycle; cache_addr is held stable. Go to CAPTURE.
- CAPTURE:
  - cache_read=0.
  - Register cache_read_data, cache_l1_hit and cache_l2_hit into resp_data, resp_l1_hit and resp_l2_hit.
  - Increment exactly one counter: l1_hit -> stat_l1_hits; else l2_hit -> stat_l2_hits; else stat_misses.
  - Go to RESP.
- RESP:
  - resp_valid[grant_id]=1 and all other resp_valid bits are 0.
  - resp_data and the hit flags are held stable.
  - When resp_ready[grant_id]=1: go to IDLE and clear resp_valid on that edge.
  - resp_ready bits of non-granted requesters are ignored.
- Latency: a request accepted at edge E asserts resp_valid in the cycle after E+2, i.e. 3 cycles after acceptance.
  - Maximum throughput is one request per 4 cycles, given zero-wait resp_ready.
- req_ready is never high outside IDLE.
  - A requester that drops req_valid before being granted loses nothing.
  - A new request cannot be accepted in the same cycle that RESP completes; the arbiter passes through IDLE first.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,3,0,...
- Counters saturate at 2^CNT_WIDTH-1.
  - stat_clear zeroes all three counters on the next edge.
  - If stat_clear coincides with a CAPTURE increment, clear wins and the counter becomes 0.
- Reset mid-operation in ISSUE, CAPTURE or RESP: immediate return to IDLE and all outputs take their reset values. The in-flight response is discarded and no resp_valid is produced.
- If cache_l1_hit and cache_l2_hit are both 1 in CAPTURE, the access is classified as an L1 hit and both flags are forwarded unchanged.

Decomposition:
- Package cache_ctrl_pkg holds:
  - the state enum: IDLE, ISSUE, CAPTURE, RESP;
  - the localparam for the grant index width, $clog2(NUM_REQ);
  - an enum for the access class: L1_HIT, L2_HIT, MISS.
- One sub-module, rr_arbiter:
  - inputs: request vector and pointer; outputs: one-hot grant and encoded index;
  - purely combinational;
  - the pointer register stays in cache_req_arbiter.

Test Plan:
- Cold miss: after reset, req_valid[2]=1 with addr 0x123 -> req_ready[2] for 1 cycle; cache_read 1 cycle with cache_addr=0x123; resp_valid[2] 3 cycles after accept; resp_data=0x2BE (0xCAFEBABE truncated to 11 bits), l1_hit=0, l2_hit=0; stat_misses=1.
- Repeat hit: requester 2 reads 0x123 again -> resp_l1_hit=1, resp_data=0x2BE; stat_l1_hits=1; counters otherwise unchanged.
- Round-robin: requesters 0-3 all valid continuously, resp_ready tied 1 -> grants in order 0,1,2,3,0; each response arrives 4 cycles apart; the grant after the initial grant to 3 wraps to 0.
- Backpressure: hold resp_ready[1]=0 for 10 cycles during RESP -> resp_valid[1] and resp_data held stable; req_ready stays 0 for requesters 0, 2 and 3; completion occurs on the cycle resp_ready[1] rises.
- Reset mid-operation: assert rst during CAPTURE -> busy=0 immediately; no resp_valid ever appears for that request; counters read 0.
- Counter saturation and clear: preset with CNT_WIDTH=2, then issue 5 misses -> stat_misses=3. Assert stat_clear in the same cycle as a CAPTURE -> stat_misses=0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache request arbiter slice.
// Holds FSM states, access classes and the grant index width.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    L1_HIT,
    L2_HIT,
    MISS
  } acc_class_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int GNT_W = $clog2(NUM_REQ_DEF);

  // An access that reports both flags counts as an L1 hit.
  function automatic acc_class_t classify(
    input logic l1,
    input logic l2
  );
    if (l1) return L1_HIT;
    if (l2) return L2_HIT;
    return MISS;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr.
// Ports: req, ptr in; gnt (one-hot), idx, found out.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(ptr) + i) % N);
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one read-only two-level cache among NUM_REQ requesters.
// Ports: req/resp handshakes, cache read port, busy/grant_id, stats.
module cache_req_arbiter
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_l1_hit,
  output logic                          resp_l2_hit,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic                          cache_read,
  input  logic [DATA_WIDTH-1:0]         cache_read_data,
  input  logic                          cache_l1_hit,
  input  logic                          cache_l2_hit,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_l1_hits,
  output logic [CNT_WIDTH-1:0]          stat_l2_hits,
  output logic [CNT_WIDTH-1:0]          stat_misses
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  state_t               state, state_nx;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        win_idx;
  logic [NUM_REQ-1:0]   win_gnt;
  logic                 win_any;
  logic [ADDR_WIDTH-1:0] win_addr;
  acc_class_t           cls;

  rr_arbiter #(
    .N(NUM_REQ),
    .W(IW)
  ) u_rr (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .gnt  (win_gnt),
    .idx  (win_idx),
    .found(win_any)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win_any) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (resp_ready[grant_id]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) begin
      resp_valid[grant_id] = 1'b1;
    end
  end

  assign req_ready  = (state == IDLE) ? win_gnt : '0;
  assign cache_read = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign cls        = classify(cache_l1_hit, cache_l2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cache_addr  <= '0;
      resp_data   <= '0;
      resp_l1_hit <= 1'b0;
      resp_l2_hit <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win_any) begin
        cache_addr <= win_addr;
        grant_id   <= win_idx;
        rr_ptr     <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
      end
      if (state == CAPTURE) begin
        resp_data   <= cache_read_data;
        resp_l1_hit <= cache_l1_hit;
        resp_l2_hit <= cache_l2_hit;
      end
    end
  end

  // Clear has priority over a coinciding CAPTURE increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_l1_hits <= '0;
      stat_l2_hits <= '0;
      stat_misses  <= '0;
    end else if (stat_clear) begin
      stat_l1_hits <= '0;
      stat_l2_hits <= '0;
      stat_misses  <= '0;
    end else if (state == CAPTURE) begin
      unique case (cls)
        L1_HIT: if (stat_l1_hits != CNT_MAX) stat_l1_hits <= stat_l1_hits + 1'b1;
        L2_HIT: if (stat_l2_hits != CNT_MAX) stat_l2_hits <= stat_l2_hits + 1'b1;
        MISS:   if (stat_misses != CNT_MAX) stat_misses <= stat_misses + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter with a behavioural cache.
// Directed sequences, an arbitration table and random transactions.
module tb_cache_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 11;
  localparam int DW = 11;
  localparam int CW = 2;
  localparam int SMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  resp_valid;
  logic [NR-1:0]  resp_ready = '0;
  logic [DW-1:0]  resp_data;
  logic           resp_l1_hit, resp_l2_hit;
  logic [AW-1:0]  cache_addr;
  logic           cache_read;
  logic [DW-1:0]  cache_read_data = '0;
  logic           cache_l1_hit = 1'b0;
  logic           cache_l2_hit = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           stat_clear = 1'b0;
  logic [CW-1:0]  stat_l1_hits, stat_l2_hits, stat_misses;

  cache_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_l1_hit(resp_l1_hit),
    .resp_l2_hit(resp_l2_hit),
    .cache_addr(cache_addr), .cache_read(cache_read),
    .cache_read_data(cache_read_data),
    .cache_l1_hit(cache_l1_hit), .cache_l2_hit(cache_l2_hit),
    .busy(busy), .grant_id(grant_id), .stat_clear(stat_clear),
    .stat_l1_hits(stat_l1_hits), .stat_l2_hits(stat_l2_hits),
    .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural cache: direct-mapped 8-line L1 over an unbounded L2.
  logic          l1v [8];
  logic [AW-1:0] l1t [8];
  logic          l2v [2048];
  bit            force_both = 1'b0;
  logic          lk_l1, lk_l2;

  function automatic logic [DW-1:0] data_of(logic [AW-1:0] a);
    return DW'(32'hCAFEBABE ^ 32'(a ^ 11'h123));
  endfunction

  always @(posedge clk) begin
    if (cache_read) begin
      logic [2:0] s;
      s = cache_addr[2:0];
      if (force_both) begin
        lk_l1 = 1'b1; lk_l2 = 1'b1;
      end else if (l1v[s] && l1t[s] == cache_addr) begin
        lk_l1 = 1'b1; lk_l2 = 1'b0;
      end else if (l2v[cache_addr]) begin
        lk_l1 = 1'b0; lk_l2 = 1'b1;
      end else begin
        lk_l1 = 1'b0; lk_l2 = 1'b0;
      end
      l1v[s] = 1'b1;
      l1t[s] = cache_addr;
      l2v[cache_addr] = 1'b1;
      cache_read_data <= data_of(cache_addr);
      cache_l1_hit    <= lk_l1;
      cache_l2_hit    <= lk_l2;
    end
  end

  // Reference state: rr pointer and saturating statistics.
  int m_ptr = 0;
  int m_l1 = 0, m_l2 = 0, m_miss = 0;

  function automatic int pick(logic [3:0] m, int p);
    for (int i = 0; i < NR; i++) begin
      if (m[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  function automatic int sat(int v);
    return (v >= SMAX) ? SMAX : v + 1;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic check_stats(string nm);
    chk({nm, "_l1cnt"}, 32'(stat_l1_hits), 32'(m_l1));
    chk({nm, "_l2cnt"}, 32'(stat_l2_hits), 32'(m_l2));
    chk({nm, "_misscnt"}, 32'(stat_misses), 32'(m_miss));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    stat_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_l1 = 0; m_l2 = 0; m_miss = 0;
  endtask

  // One full transaction; call at a negedge with the arbiter idle.
  task automatic run_txn(input logic [3:0] mask, input logic [NR*AW-1:0] addrs,
                         input int hold, input bit clr, output int win);
    int cnt;
    int ew;
    logic [AW-1:0] a;
    logic [3:0] oh;
    win = -1;
    req_valid = mask;
    req_addr = addrs;
    resp_ready = '0;
    #1;
    cnt = 0;
    while (req_ready == '0 && cnt < 10) begin
      @(negedge clk); #1; cnt++;
    end
    if (req_ready == '0) begin
      chk("accept_timeout", 32'(req_ready), 32'(mask));
      req_valid = '0;
      return;
    end
    ew = pick(mask, m_ptr);
    oh = 4'(1 << ew);
    chk("req_ready", 32'(req_ready), 32'(oh));
    win = ew;
    m_ptr = (ew + 1) % NR;
    a = addrs[ew*AW +: AW];
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("issue_read", 32'(cache_read), 1);
    chk("issue_addr", 32'(cache_addr), 32'(a));
    chk("grant_id", 32'(grant_id), 32'(ew));
    chk("issue_busy", 32'(busy), 1);
    @(negedge clk);
    chk("capture_read", 32'(cache_read), 0);
    chk("capture_valid", 32'(resp_valid), 0);
    if (clr) stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    if (clr) begin
      m_l1 = 0; m_l2 = 0; m_miss = 0;
    end else if (lk_l1) m_l1 = sat(m_l1);
    else if (lk_l2) m_l2 = sat(m_l2);
    else m_miss = sat(m_miss);
    chk("resp_valid", 32'(resp_valid), 32'(oh));
    chk("resp_data", 32'(resp_data), 32'(data_of(a)));
    chk("resp_l1", 32'(resp_l1_hit), 32'(lk_l1));
    chk("resp_l2", 32'(resp_l2_hit), 32'(lk_l2));
    check_stats("resp");
    for (int h = 0; h < hold; h++) begin
      req_valid = ~oh;
      resp_ready = ~oh;
      #1;
      chk("hold_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'(oh));
      chk("hold_data", 32'(resp_data), 32'(data_of(a)));
    end
    req_valid = '0;
    resp_ready = oh;
    @(negedge clk);
    resp_ready = '0;
    chk("done_valid", 32'(resp_valid), 0);
    chk("done_busy", 32'(busy), 0);
  endtask

  typedef struct {
    logic [3:0] mask;
    int         win;
  } arb_vec_t;

  arb_vec_t tbl [8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g, gcyc, prev, ng;
    logic [NR*AW-1:0] ad;
    logic saw;

    for (int i = 0; i < 8; i++) begin
      l1v[i] = 1'b0; l1t[i] = '0;
    end
    for (int i = 0; i < 2048; i++) l2v[i] = 1'b0;

    tbl[0] = '{4'b0100, 2};
    tbl[1] = '{4'b0111, 0};
    tbl[2] = '{4'b1111, 1};
    tbl[3] = '{4'b1001, 3};
    tbl[4] = '{4'b1010, 1};
    tbl[5] = '{4'b0011, 0};
    tbl[6] = '{4'b0001, 0};
    tbl[7] = '{4'b1000, 3};

    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_addr", 32'(cache_addr), 0);
    chk("rst_read", 32'(cache_read), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_data", 32'(resp_data), 0);
    chk("rst_flags", 32'({resp_l1_hit, resp_l2_hit}), 0);
    chk("rst_ready", 32'(req_ready), 0);
    check_stats("rst");
    @(negedge clk);

    // Cold miss then repeat hit at 0x123 from requester 2.
    ad = {4{11'h123}};
    run_txn(4'b0100, ad, 0, 1'b0, w);
    chk("cold_win", 32'(w), 2);
    chk("cold_data", 32'(resp_data), 32'h2BE);
    chk("cold_flags", 32'({resp_l1_hit, resp_l2_hit}), 0);
    chk("cold_miss_cnt", 32'(stat_misses), 1);
    run_txn(4'b0100, ad, 0, 1'b0, w);
    chk("hit_l1", 32'(resp_l1_hit), 1);
    chk("hit_data", 32'(resp_data), 32'h2BE);
    chk("hit_l1_cnt", 32'(stat_l1_hits), 1);
    chk("hit_miss_cnt", 32'(stat_misses), 1);

    // Arbitration table from a fresh pointer.
    do_reset();
    foreach (tbl[k]) begin
      for (int r = 0; r < NR; r++) ad[r*AW +: AW] = AW'($urandom_range(0, 31));
      run_txn(tbl[k].mask, ad, 0, 1'b0, w);
      chk("tbl_win", 32'(w), 32'(tbl[k].win));
    end

    // Backpressure on requester 1 for 10 cycles.
    run_txn(4'b0010, {4{11'h055}}, 10, 1'b0, w);
    chk("bp_win", 32'(w), 1);

    // Continuous requests with zero-wait responses.
    do_reset();
    req_valid = 4'hF;
    resp_ready = 4'hF;
    ng = 0; prev = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (req_ready != '0 && ng < 5) begin
        g = -1;
        for (int r = 0; r < NR; r++) if (req_ready[r]) g = r;
        gcyc = c;
        chk("rr_order", 32'(g), 32'(ng % NR));
        if (ng > 0) chk("rr_spacing", 32'(gcyc - prev), 4);
        prev = gcyc;
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_count", 32'(ng), 5);
    req_valid = '0;

    // Reset during CAPTURE discards the request.
    do_reset();
    req_valid = 4'b0001;
    req_addr = {4{11'h3A1}};
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_read", 32'(cache_read), 0);
    chk("mid_valid", 32'(resp_valid), 0);
    chk("mid_addr", 32'(cache_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_l1 = 0; m_l2 = 0; m_miss = 0;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid != '0) saw = 1'b1;
    end
    chk("mid_no_resp", 32'(saw), 0);
    check_stats("mid");

    // Saturation at 3, then clear coinciding with CAPTURE.
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b0001, {4{AW'(11'h400 + k)}}, 0, 1'b0, w);
    end
    chk("sat_misses", 32'(stat_misses), 3);
    run_txn(4'b0001, {4{11'h410}}, 0, 1'b1, w);
    chk("clr_misses", 32'(stat_misses), 0);

    // Both flags set classify as L1 and pass through unchanged.
    force_both = 1'b1;
    run_txn(4'b0100, {4{11'h420}}, 0, 1'b0, w);
    force_both = 1'b0;
    chk("both_flags", 32'({resp_l1_hit, resp_l2_hit}), 3);
    chk("both_l1cnt", 32'(stat_l1_hits), 1);
    chk("both_l2cnt", 32'(stat_l2_hits), 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < NR; r++) ad[r*AW +: AW] = AW'($urandom_range(0, 31));
      run_txn(4'($urandom_range(1, 15)), ad, $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
